input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop count; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a level change; legal range 2..65535.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 Port Data_in  input  1: raw asynchronous level, e.g. a switch or button.
REQ-006 Port Data_out  output  1: debounced, synchronized level; feeds the downstream D flip-flop Data_in.
REQ-007 Port Enable  output  1: one-cycle strobe on each accepted level change; feeds the downstream flip-flop Enable.
REQ-008 Port Rise  output  1: one-cycle strobe when Data_out goes 0->1.
REQ-009 Port Fall  output  1: one-cycle strobe when Data_out goes 1->0.

Function
REQ-010 Data_in shall pass through a SYNC_STAGES-deep flop chain; sync_q denotes the last stage; no other logic shall read Data_in.
REQ-011 The FSM shall have exactly four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 STABLE_LO: sync_q=1 -> WAIT_HI with count=1; else hold with count=0.
REQ-013 WAIT_HI: sync_q=0 -> STABLE_LO with count=0 and no strobe; sync_q=1 and count=DEBOUNCE_CYCLES-1 -> STABLE_HI; else count+1.
REQ-014 STABLE_HI and WAIT_LO shall mirror REQ-012/013 with levels inverted.
REQ-015 Data_out shall be registered and equal 1 exactly in STABLE_HI and WAIT_LO.
REQ-016 Enable shall be registered and assert for exactly the one cycle after the edge that enters STABLE_HI from WAIT_HI or STABLE_LO from WAIT_LO; it is 0 in all other cycles.
REQ-017 Rise and Fall shall be registered and coincident with Enable, qualified by direction; they are never both 1.
REQ-018 Latency: Data_out shall change on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new Data_in level, provided Data_in holds throughout.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES samples at sync_q shall produce no change on Data_out, Enable, Rise or Fall.
REQ-020 The counter width shall be $clog2(DEBOUNCE_CYCLES+1); the counter shall saturate and never wrap.
REQ-021 Back-to-back accepted changes shall be separated by at least DEBOUNCE_CYCLES cycles; Enable shall never be high on two consecutive cycles.

Reset
REQ-022 While reset=0: all sync flops, count, Data_out, Enable, Rise and Fall shall be 0, with state STABLE_LO.
REQ-023 Reset asserted mid-WAIT shall abort the pending change with no strobe.
REQ-024 After reset deassertion, a Data_in held at 1 shall be accepted as a normal 0->1 change per REQ-018, including the Enable and Rise strobes.
REQ-025 Reset deassertion shall be used as-is; the block shall not synchronize it internally.

Configuration
REQ-026 With macro INPUT_DEBOUNCER_EDGE_EN defined, Rise and Fall shall behave per REQ-017.
REQ-027 Without INPUT_DEBOUNCER_EDGE_EN, the Rise and Fall ports shall remain present but be tied to constant 0, with no edge registers instantiated; Data_out and Enable shall be unchanged.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, clk period 100)
REQ-028 Reset=0 for 100, with Data_in=1 throughout -> all outputs 0 during reset; Data_out=1 on the 6th edge after release, with Enable=Rise=1 for one cycle.
REQ-029 Data_in pulses 1 for 200 (2 samples) from a stable 0 -> Data_out, Enable, Rise and Fall all stay 0.
REQ-030 Data_in goes 0->1 and is held for 1000 -> Data_out=1 on edge 6 with a single Enable pulse; then 1->0 held -> Data_out=0 six edges later with Enable=Fall=1 for one cycle.
REQ-031 Data_in goes high, then reset=0 is asserted after 3 edges -> outputs 0 immediately and no strobe is emitted.
REQ-032 Rebuild without INPUT_DEBOUNCER_EDGE_EN and rerun REQ-030 -> identical Data_out and Enable; Rise and Fall constant 0.
REQ-033 Data_in toggles every 100 for 2000 -> no Enable pulse ever; Enable is never high on two consecutive cycles in any test.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw-input source and the input_debouncer block.
// The master drives the raw level; the slave returns the debounced level and strobes.
interface input_debouncer_if;
  logic Data_in;
  logic Data_out;
  logic Enable;
  logic Rise;
  logic Fall;

  modport master (output Data_in, input Data_out, input Enable, input Rise, input Fall);
  modport slave  (input Data_in, output Data_out, output Enable, output Rise, output Fall);
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw level, emitting accept/rise/fall strobes.
// Define INPUT_DEBOUNCER_EDGE_EN to build the Rise/Fall edge registers; otherwise they read 0.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input_debouncer_if.slave   dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_syncQ;
  state_t                 r_state;
  state_t                 w_nextState;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_nextCount;
  logic [CW-1:0]          w_countInc;
  logic                   w_accept;
  logic                   r_dataOut;
  logic                   r_enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], dbg.Data_in};
    end
  end

  assign w_syncQ    = r_sync[SYNC_STAGES-1];
  assign w_countInc = (r_count == {CW{1'b1}}) ? r_count : r_count + ONE_COUNT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STABLE_LO;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES agreeing samples; any disagreement aborts silently.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = '0;
    w_accept    = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (w_syncQ) begin
          w_nextState = WAIT_HI;
          w_nextCount = ONE_COUNT;
        end
      end
      WAIT_HI: begin
        if (!w_syncQ) begin
          w_nextState = STABLE_LO;
        end else if (r_count == LAST_COUNT) begin
          w_nextState = STABLE_HI;
          w_accept    = 1'b1;
        end else begin
          w_nextCount = w_countInc;
        end
      end
      STABLE_HI: begin
        if (!w_syncQ) begin
          w_nextState = WAIT_LO;
          w_nextCount = ONE_COUNT;
        end
      end
      WAIT_LO: begin
        if (w_syncQ) begin
          w_nextState = STABLE_HI;
        end else if (r_count == LAST_COUNT) begin
          w_nextState = STABLE_LO;
          w_accept    = 1'b1;
        end else begin
          w_nextCount = w_countInc;
        end
      end
      default: begin
        w_nextState = STABLE_LO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dataOut <= 1'b0;
      r_enable  <= 1'b0;
    end else begin
      r_dataOut <= (w_nextState == STABLE_HI) || (w_nextState == WAIT_LO);
      r_enable  <= w_accept;
    end
  end

  assign dbg.Data_out = r_dataOut;
  assign dbg.Enable   = r_enable;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept && (w_nextState == STABLE_HI);
      r_fall <= w_accept && (w_nextState == STABLE_LO);
    end
  end

  assign dbg.Rise = r_rise;
  assign dbg.Fall = r_fall;
`else
  assign dbg.Rise = 1'b0;
  assign dbg.Fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 100-unit clock).
// A run-length model of the debounce rule is compared every cycle, plus hand-computed checkpoints.
module tb_input_debouncer;

  localparam int SYNC   = 2;
  localparam int DEB    = 4;
`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  input_debouncer_if dbg();

  input_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic got, input logic expected);
    checkCount++;
    if (got === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b at time %0t", name, got, expected, $time);
    end
  endtask

  // Model: the output flips once DEB consecutive synchronized samples disagree with it.
  logic mOut;
  logic mEn;
  logic mRise;
  logic mFall;
  int   mRun;
  logic mSamples[$];

  initial begin
    logic syncQ;
    mOut = 1'b0; mEn = 1'b0; mRise = 1'b0; mFall = 1'b0; mRun = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (reset !== 1'b1) begin
        mSamples.delete();
        mRun = 0; mOut = 1'b0; mEn = 1'b0; mRise = 1'b0; mFall = 1'b0;
      end else if (clk === 1'b1) begin
        syncQ = 1'b0;
        if (mSamples.size() == SYNC) syncQ = mSamples.pop_front();
        mSamples.push_back(dbg.Data_in);
        mEn = 1'b0; mRise = 1'b0; mFall = 1'b0;
        if (syncQ != mOut) begin
          mRun++;
          if (mRun == DEB) begin
            mOut  = syncQ;
            mEn   = 1'b1;
            mRise = EDGE & syncQ;
            mFall = EDGE & ~syncQ;
            mRun  = 0;
          end
        end else begin
          mRun = 0;
        end
      end
    end
  end

  logic prevEnable;
  initial begin
    prevEnable = 1'b0;
    forever begin
      @(negedge clk);
      checkOutput("cmpDataOut", dbg.Data_out, mOut);
      checkOutput("cmpEnable",  dbg.Enable,   mEn);
      checkOutput("cmpRise",    dbg.Rise,     mRise);
      checkOutput("cmpFall",    dbg.Fall,     mFall);
      if (dbg.Enable === 1'b1) checkOutput("enableNotBackToBack", prevEnable, 1'b0);
      prevEnable = dbg.Enable;
    end
  end

  // Drive Data_in just after an edge and let the given number of rising edges pass.
  task automatic applyStimulus(input logic level, input int edges);
    dbg.Data_in = level;
    repeat (edges) begin
      @(posedge clk);
    end
    #5;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset       = 1'b0;
    dbg.Data_in = 1'b1;

    // Reset held with input high: everything reads 0.
    @(posedge clk); #5;
    checkOutput("resetDataOut", dbg.Data_out, 1'b0);
    checkOutput("resetEnable",  dbg.Enable,   1'b0);
    checkOutput("resetRise",    dbg.Rise,     1'b0);
    #50;
    reset = 1'b1;
    applyStimulus(1'b1, 5);
    checkOutput("relEdge5DataOut", dbg.Data_out, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("relEdge6DataOut", dbg.Data_out, 1'b1);
    checkOutput("relEdge6Enable",  dbg.Enable,   1'b1);
    checkOutput("relEdge6Rise",    dbg.Rise,     EDGE);
    applyStimulus(1'b1, 1);
    checkOutput("relEdge7Enable",  dbg.Enable,   1'b0);

    // Falling acceptance from stable high, six edges after the change.
    applyStimulus(1'b0, 5);
    checkOutput("fallEdge5DataOut", dbg.Data_out, 1'b1);
    applyStimulus(1'b0, 1);
    checkOutput("fallEdge6DataOut", dbg.Data_out, 1'b0);
    checkOutput("fallEdge6Fall",    dbg.Fall,     EDGE);
    checkOutput("fallEdge6Rise",    dbg.Rise,     1'b0);

    // Two-sample glitch from stable low is ignored.
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 8);
    checkOutput("glitchLoDataOut", dbg.Data_out, 1'b0);

    // Held high change, a three-sample low glitch, then a held low change.
    applyStimulus(1'b1, 5);
    checkOutput("holdHiEdge5", dbg.Data_out, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("holdHiEdge6",       dbg.Data_out, 1'b1);
    checkOutput("holdHiEdge6Enable", dbg.Enable,   1'b1);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 8);
    checkOutput("glitchHiDataOut", dbg.Data_out, 1'b1);
    applyStimulus(1'b0, 5);
    checkOutput("holdLoEdge5", dbg.Data_out, 1'b1);
    applyStimulus(1'b0, 1);
    checkOutput("holdLoEdge6",     dbg.Data_out, 1'b0);
    checkOutput("holdLoEdge6Fall", dbg.Fall,     EDGE);
    applyStimulus(1'b0, 3);

    // Reset mid-wait aborts the pending change; a held high is re-accepted afterwards.
    applyStimulus(1'b1, 3);
    reset = 1'b0;
    #1;
    checkOutput("abortDataOut", dbg.Data_out, 1'b0);
    checkOutput("abortEnable",  dbg.Enable,   1'b0);
    repeat (2) @(posedge clk);
    #4;
    checkOutput("abortHoldEnable", dbg.Enable, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 5);
    checkOutput("reacceptEdge5", dbg.Data_out, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("reacceptEdge6",     dbg.Data_out, 1'b1);
    checkOutput("reacceptEdge6Rise", dbg.Rise,     EDGE);
    applyStimulus(1'b0, 10);
    checkOutput("settleLow", dbg.Data_out, 1'b0);

    // Input toggling every cycle never settles.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(~dbg.Data_in, 1);
    end
    applyStimulus(1'b0, 2);
    checkOutput("toggleDataOut", dbg.Data_out, 1'b0);

    // Random hold lengths around the acceptance threshold, checked by the model.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end
    applyStimulus(1'b0, 10);
    checkOutput("finalDataOut", dbg.Data_out, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
